// File: rtl/bj_disp_pkg.sv
// Shared types and constants for the blackjack display path.
// Holds the converter FSM encoding and the BCD range helpers.
package bj_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  localparam int          BCD_W    = 4;
  localparam logic [3:0]  BCD_NINE = 4'h9;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/dabble_digit.sv
// One BCD digit of the double-dabble correction: add 3 when the digit is 5 or more.
module dabble_digit
  import bj_disp_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per cycle, saturating at 10**DIGITS-1.
// Results are registered and held until the next conversion finishes.
module bin_to_bcd_seq
  import bj_disp_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int SD = DIGITS + 1;
  localparam int SW = SD * BCD_W;
  localparam int CW = $clog2(BIN_W + 1);
  localparam longint unsigned LIMIT = pow10(DIGITS) - 64'd1;
  // When every BIN_W-bit value fits in DIGITS digits the range check folds away.
  localparam bit OVF_POSSIBLE = (BIN_W >= 64) || (((64'd1 << BIN_W) - 64'd1) > LIMIT);

  state_t                       state, state_nxt;
  logic [CW-1:0]                cnt;
  logic [BIN_W-1:0]             shreg;
  logic [SD-1:0][BCD_W-1:0]     scratch;
  logic [SD-1:0][BCD_W-1:0]     adj;
  logic [SW+BIN_W-1:0]          cat_sh;
  logic                         lost;
  logic                         ovf_hit;

  for (genvar g = 0; g < SD; g++) begin : g_dig
    dabble_digit u_dig (.d(scratch[g]), .q(adj[g]));
  end

  assign cat_sh  = {adj, shreg} << 1;
  // A bit shifted out of the top digit means the value exceeded the scratch width.
  assign ovf_hit = OVF_POSSIBLE && (lost || (scratch[SD-1] != '0));
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      scratch <= '0;
      lost    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      ovf     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          shreg   <= bin_in;
          scratch <= '0;
          lost    <= 1'b0;
          cnt     <= CW'(BIN_W);
        end
        SHIFT: begin
          scratch <= cat_sh[SW+BIN_W-1 -: SW];
          shreg   <= cat_sh[BIN_W-1:0];
          lost    <= lost | adj[SD-1][BCD_W-1];
          cnt     <= cnt - CW'(1);
        end
        FIN: begin
          done <= 1'b1;
          if (ovf_hit) begin
            bcd_out <= {DIGITS{BCD_NINE}};
            ovf     <= 1'b1;
          end else begin
            bcd_out <= scratch[DIGITS-1:0];
            ovf     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: an 8-bit and a 10-bit instance, each with its own
// expected-result queue popped by a monitor on every done pulse.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start8 = 1'b0, start10 = 1'b0;
  logic [7:0]  bin8 = '0;
  logic [9:0]  bin10 = '0;
  logic        busy8, done8, ovf8, busy10, done10, ovf10;
  logic [11:0] bcd8, bcd10;

  int tests = 0;
  int fails = 0;
  logic [12:0] q8[$];
  logic [12:0] q10[$];
  logic [11:0] prev8 = '0, prev10 = '0;
  logic        pov8 = 1'b0, pov10 = 1'b0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .bin_in(bin8),
    .busy(busy8), .done(done8), .bcd_out(bcd8), .ovf(ovf8));

  bin_to_bcd_seq #(.BIN_W(10), .DIGITS(3)) dut10 (
    .clk(clk), .rst_n(rst_n), .start(start10), .bin_in(bin10),
    .busy(busy10), .done(done10), .bcd_out(bcd10), .ovf(ovf10));

  // Reference: decimal digits by division, saturating above 999.
  function automatic logic [12:0] ref_conv(input int v);
    logic [3:0] h, t, o;
    if (v > 999) return {1'b1, 12'h999};
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {1'b0, h, t, o};
  endfunction

  function automatic bit digits_ok(input logic [11:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitors: pop on done, otherwise require held outputs; digits valid every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev8 = '0; pov8 = 1'b0;
    end else begin
      check("digits8", 32'(digits_ok(bcd8)), 32'd1);
      if (done8) begin
        if (q8.size() == 0) check("unexpected_done8", 32'd1, 32'd0);
        else check("result8", {19'd0, ovf8, bcd8}, {19'd0, q8.pop_front()});
      end else begin
        check("stable8", {19'd0, ovf8, bcd8}, {19'd0, pov8, prev8});
      end
      prev8 = bcd8; pov8 = ovf8;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev10 = '0; pov10 = 1'b0;
    end else begin
      check("digits10", 32'(digits_ok(bcd10)), 32'd1);
      if (done10) begin
        if (q10.size() == 0) check("unexpected_done10", 32'd1, 32'd0);
        else check("result10", {19'd0, ovf10, bcd10}, {19'd0, q10.pop_front()});
      end else begin
        check("stable10", {19'd0, ovf10, bcd10}, {19'd0, pov10, prev10});
      end
      prev10 = bcd10; pov10 = ovf10;
    end
  end

  // Issue one request on the 8-bit unit and wait for its done, checking latency.
  task automatic go8(input int v);
    int k;
    @(negedge clk);
    start8 = 1'b1; bin8 = 8'(v);
    q8.push_back(ref_conv(v));
    @(negedge clk);
    start8 = 1'b0; bin8 = 8'($urandom);
    check("busy8_after_accept", 32'(busy8), 32'd1);
    k = 0;
    while (!done8 && k < 50) begin @(negedge clk); k++; end
    check("latency8", 32'(k), 32'd9);
  endtask

  task automatic go10(input int v);
    int k;
    @(negedge clk);
    start10 = 1'b1; bin10 = 10'(v);
    q10.push_back(ref_conv(v));
    @(negedge clk);
    start10 = 1'b0;
    k = 0;
    while (!done10 && k < 50) begin @(negedge clk); k++; end
    check("latency10", 32'(k), 32'd11);
  endtask

  initial begin
    int k;
    #12;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_bcd", 32'(bcd8), 32'd0);
    check("rst_ovf", 32'(ovf8), 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;

    go8(0);
    go8(21);
    go8(255);

    // Requests during the busy window (including FIN) are dropped.
    @(negedge clk);
    start8 = 1'b1; bin8 = 8'd21;
    q8.push_back(ref_conv(21));
    k = 0;
    do begin
      @(negedge clk);
      start8 = 1'b1; bin8 = 8'd17;
      k++;
    end while (!done8 && k < 50);
    start8 = 1'b0;
    check("busy_window_done_seen", 32'(done8), 32'd1);
    go8(17);

    // Abort on the fourth SHIFT cycle of 99; no done and no result expected.
    @(negedge clk);
    start8 = 1'b1; bin8 = 8'd99;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_bcd", 32'(bcd8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (15) @(negedge clk);
    go8(99);

    go10(1000);
    go10(999);
    go10(1023);
    repeat (30) go10(int'($urandom_range(1023, 0)));

    for (int v = 0; v < 256; v++) go8(v);
    repeat (30) go8(int'($urandom_range(255, 0)));

    repeat (5) @(negedge clk);
    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q10_drained", 32'(q10.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
